sisc_ctrl_fsm_v2: RTL
=====================

// Module: sisc_ctrl_fsm_v2
// PURPOSE
//  Second-generation SISC control FSM: sequences fetch/decode/execute/mem/writeback and drives all
//  datapath control strobes. Adds a req/ack memory handshake with wait-state timeout, a resumable
//  HALT state in place of simulation stop, registered branch resolution and a retired-instruction counter.
//  Sits between the instruction register (opcode/mm) and the PC, RF, ALU, data-memory and muxes.
// PARAMETERS
//  STATW        4   width of mm field and stat flags; branch mask compare width
//  CNTW         16  width of instr_count
//  MEM_WAIT_MAX 15  max cycles a FETCH/MEM access may wait for mem_ack before error halt (>=1)
//  IMM_MODE     8   mm value selecting immediate ALU operand
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst         in   1      synchronous, active-high reset
//  opcode      in   4      IR opcode: 0 NOOP,1 LOD,2 STR,3 SWP,4 BRA,5 BRR,6 BNE,7 BNR,8 ALU,15 HLT
//  mm          in   STATW  IR mode / branch mask
//  stat        in   STATW  status flags
//  mem_ack     in   1      memory access complete this cycle
//  resume      in   1      single-cycle pulse: leave HALT
//  pc_rst      out  1      reset PC to 0
//  pc_write    out  1      load PC with selected value
//  pc_sel      out  1      1 = branch target, 0 = PC+1
//  br_sel      out  1      1 = absolute target, 0 = relative
//  rd_sel      out  1      1 = RF read port 2 uses dest field (stores)
//  ir_load     out  1      load IR from read_data
//  rf_we       out  1      RF write enable
//  alu_op      out  2      00 reg/reg, 01 imm/addr, 10 PC increment
//  wb_sel      out  2      00 ALU, 01 memory, 10/11 swap paths
//  load_sel    out  2      00 imm, 01 abs, 10 reg-indirect
//  dm_we       out  1      data-memory write enable
//  wr_sel      out  1      RF write-address select
//  mem_req     out  1      memory access request
//  halted      out  1      FSM in HALT
//  mem_err     out  1      sticky: handshake timeout occurred
//  instr_count out  CNTW   retired instructions, wraps to 0
// BEHAVIOUR
//  States: START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT. rst (sync) -> START0.
//  Reset values: pc_rst=1, all other strobes 0, pc_sel=br_sel=0, mem_err=0, instr_count=0.
//  START0->START1->FETCH unconditionally; pc_rst=1 in START0 and START1 only.
//  FETCH: mem_req=1; ir_load=mem_ack; ->DECODE on mem_ack, else wait.
//  DECODE: rd_sel=(opcode==STR). Register pc_sel, br_sel (held until next DECODE):
//   cond = |(mm & stat); mm==0 => taken. BRA/BRR taken on cond, BNE/BNR on !cond; others pc_sel=0.
//   br_sel=1 for BRA/BNE, 0 for BRR/BNR. opcode HLT -> HALT; else -> EXECUTE.
//  EXECUTE: alu_op=01 if mm==IMM_MODE or opcode LOD/STR, else 00. ->MEM.
//  MEM: LOD/STR assert mem_req, dm_we=(STR & mem_req); stay until mem_ack. Others 1 cycle.
//   SWP: rf_we=1, wr_sel=1, wb_sel=11. load_sel: mm in {IMM_MODE,IMM_MODE+1}->00, mm==0->01, else 10.
//  WRITEBACK (1 cycle): pc_write=1, alu_op=10; ALU: rf_we=1 wb_sel=00; LOD: rf_we=1 wb_sel=01;
//   SWP: rf_we=1 wb_sel=10; STR/NOOP/branches: rf_we=0. instr_count+=1 (mod 2^CNTW). ->FETCH.
//  Wait counter: cleared on entry to FETCH/MEM; if MEM_WAIT_MAX cycles elapse without mem_ack,
//   set mem_err, drop mem_req, ->HALT. mem_ack on the last allowed cycle is accepted.
//  HALT: halted=1, all strobes 0. resume with mem_err=0 -> WRITEBACK (PC advances past HLT);
//   resume ignored when mem_err=1; only rst clears mem_err.
//  Strobes are combinational from state+opcode/mm; no strobe may glitch between states.
//  rst in any state, incl. mid-handshake, wins: next cycle START0, mem_req=0.
// TESTING
//  rst 1 cycle -> START0,START1 pc_rst=1; FETCH mem_req=1; ack after 3 waits -> ir_load 1 cycle.
//  ALU mm=8, ack immediate -> EXECUTE alu_op=01, WRITEBACK rf_we=1 wb_sel=00 pc_write=1, count=1.
//  BNE mm=0100 stat=0100 -> pc_sel=0; stat=0010 -> pc_sel=1, br_sel=1; BRR mm=0 -> pc_sel=1 br_sel=0.
//  LOD with mem_ack withheld MEM_WAIT_MAX cycles -> mem_err=1, halted=1; resume ignored; rst clears.
//  HLT -> halted=1 5 cycles, resume -> WRITEBACK pc_write=1 rf_we=0 -> FETCH; CNTW=4, 16 instrs -> count=0.
//  rst asserted during MEM wait of STR -> dm_we/mem_req 0 next cycle, state START0.

Source files
------------

// File: rtl/sisc_ctrl_fsm_v2.sv
// sisc_ctrl_fsm_v2: SISC control FSM. Sequences fetch/decode/execute/mem/writeback and drives
// the datapath control strobes. Memory accesses (FETCH, and MEM for LOD/STR) use a req/ack
// handshake: mem_req_o is held for at most MEM_WAIT_MAX cycles, an ack in any of those cycles
// is accepted, and if none arrives the FSM sets the sticky mem_err_o and parks in HALT.
// HALT is left on a resume_i pulse (through WRITEBACK, so the PC steps past HLT) unless
// mem_err_o is set; only rst_i clears mem_err_o.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   opcode_i, mm_i        instruction register opcode and mode/branch-mask field
//   stat_i                status flags for branch resolution
//   mem_ack_i             memory access complete this cycle
//   resume_i              leave HALT (single-cycle pulse)
//   pc_rst_o .. wr_sel_o  datapath strobes, combinational from state and IR fields
//   pc_sel_o, br_sel_o    branch resolution, registered in DECODE, held until next DECODE
//   mem_req_o             memory access request
//   halted_o, mem_err_o   FSM in HALT / sticky handshake timeout
//   instr_count_o         retired instructions, wraps modulo 2^CNTW
module sisc_ctrl_fsm_v2 #(
    parameter int unsigned STATW        = 4,
    parameter int unsigned CNTW         = 16,
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned IMM_MODE     = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       opcode_i,
    input  logic [STATW-1:0] mm_i,
    input  logic [STATW-1:0] stat_i,
    input  logic             mem_ack_i,
    input  logic             resume_i,
    output logic             pc_rst_o,
    output logic             pc_write_o,
    output logic             pc_sel_o,
    output logic             br_sel_o,
    output logic             rd_sel_o,
    output logic             ir_load_o,
    output logic             rf_we_o,
    output logic [1:0]       alu_op_o,
    output logic [1:0]       wb_sel_o,
    output logic [1:0]       load_sel_o,
    output logic             dm_we_o,
    output logic             wr_sel_o,
    output logic             mem_req_o,
    output logic             halted_o,
    output logic             mem_err_o,
    output logic [CNTW-1:0]  instr_count_o
);

    localparam int unsigned WaitW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

    localparam logic [3:0] OpNoop = 4'd0;
    localparam logic [3:0] OpLod  = 4'd1;
    localparam logic [3:0] OpStr  = 4'd2;
    localparam logic [3:0] OpSwp  = 4'd3;
    localparam logic [3:0] OpBra  = 4'd4;
    localparam logic [3:0] OpBrr  = 4'd5;
    localparam logic [3:0] OpBne  = 4'd6;
    localparam logic [3:0] OpBnr  = 4'd7;
    localparam logic [3:0] OpAlu  = 4'd8;
    localparam logic [3:0] OpHlt  = 4'd15;

    typedef enum logic [2:0] {
        StStart0, StStart1, StFetch, StDecode, StExecute, StMem, StWriteback, StHalt
    } state_e;

    state_e            state_q, state_d;
    logic              pc_sel_q, pc_sel_d;
    logic              br_sel_q, br_sel_d;
    logic              mem_err_q, mem_err_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WaitW-1:0]  wait_q, wait_d;

    logic is_mem_op;
    logic is_imm;
    logic last_wait;
    logic cond;

    assign is_mem_op = (opcode_i == OpLod) || (opcode_i == OpStr);
    assign is_imm    = (mm_i == STATW'(IMM_MODE));
    // Index of the final cycle an access may spend waiting for ack.
    assign last_wait = (wait_q == WaitW'(MEM_WAIT_MAX - 1));
    // Empty mask means unconditional.
    assign cond      = (|(mm_i & stat_i)) || (mm_i == '0);

    always_comb begin
        state_d   = state_q;
        pc_sel_d  = pc_sel_q;
        br_sel_d  = br_sel_q;
        mem_err_d = mem_err_q;
        cnt_d     = cnt_q;
        wait_d    = '0;
        unique case (state_q)
            StStart0: state_d = StStart1;
            StStart1: state_d = StFetch;
            StFetch: begin
                if (mem_ack_i) begin
                    state_d = StDecode;
                end else if (last_wait) begin
                    mem_err_d = 1'b1;
                    state_d   = StHalt;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StDecode: begin
                unique case (opcode_i)
                    OpBra: begin pc_sel_d = cond;  br_sel_d = 1'b1; end
                    OpBne: begin pc_sel_d = !cond; br_sel_d = 1'b1; end
                    OpBrr: begin pc_sel_d = cond;  br_sel_d = 1'b0; end
                    OpBnr: begin pc_sel_d = !cond; br_sel_d = 1'b0; end
                    default: begin pc_sel_d = 1'b0; br_sel_d = 1'b0; end
                endcase
                state_d = (opcode_i == OpHlt) ? StHalt : StExecute;
            end
            StExecute: state_d = StMem;
            StMem: begin
                if (!is_mem_op || mem_ack_i) begin
                    state_d = StWriteback;
                end else if (last_wait) begin
                    mem_err_d = 1'b1;
                    state_d   = StHalt;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StWriteback: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = StFetch;
            end
            StHalt: begin
                if (resume_i && !mem_err_q) begin
                    state_d = StWriteback;
                end
            end
            default: state_d = StStart0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StStart0;
            pc_sel_q  <= 1'b0;
            br_sel_q  <= 1'b0;
            mem_err_q <= 1'b0;
            cnt_q     <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_sel_q  <= pc_sel_d;
            br_sel_q  <= br_sel_d;
            mem_err_q <= mem_err_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        pc_rst_o   = 1'b0;
        pc_write_o = 1'b0;
        rd_sel_o   = 1'b0;
        ir_load_o  = 1'b0;
        rf_we_o    = 1'b0;
        alu_op_o   = 2'b00;
        wb_sel_o   = 2'b00;
        load_sel_o = 2'b00;
        dm_we_o    = 1'b0;
        wr_sel_o   = 1'b0;
        mem_req_o  = 1'b0;
        halted_o   = 1'b0;
        unique case (state_q)
            StStart0, StStart1: pc_rst_o = 1'b1;
            StFetch: begin
                mem_req_o = 1'b1;
                ir_load_o = mem_ack_i;
            end
            StDecode: rd_sel_o = (opcode_i == OpStr);
            StExecute: alu_op_o = (is_imm || is_mem_op) ? 2'b01 : 2'b00;
            StMem: begin
                if (is_imm || (mm_i == STATW'(IMM_MODE + 1))) begin
                    load_sel_o = 2'b00;
                end else if (mm_i == '0) begin
                    load_sel_o = 2'b01;
                end else begin
                    load_sel_o = 2'b10;
                end
                if (is_mem_op) begin
                    mem_req_o = 1'b1;
                    dm_we_o   = (opcode_i == OpStr);
                end else if (opcode_i == OpSwp) begin
                    rf_we_o  = 1'b1;
                    wr_sel_o = 1'b1;
                    wb_sel_o = 2'b11;
                end
            end
            StWriteback: begin
                pc_write_o = 1'b1;
                alu_op_o   = 2'b10;
                unique case (opcode_i)
                    OpAlu: begin rf_we_o = 1'b1; wb_sel_o = 2'b00; end
                    OpLod: begin rf_we_o = 1'b1; wb_sel_o = 2'b01; end
                    OpSwp: begin rf_we_o = 1'b1; wb_sel_o = 2'b10; end
                    default: rf_we_o = 1'b0;
                endcase
            end
            StHalt: halted_o = 1'b1;
            default: pc_rst_o = 1'b0;
        endcase
    end

    assign pc_sel_o      = pc_sel_q;
    assign br_sel_o      = br_sel_q;
    assign mem_err_o     = mem_err_q;
    assign instr_count_o = cnt_q;

endmodule
